psum_accum_ctrl: RTL and testbench

- Sequences partial-sum accumulation for one output channel across input-channel groups.
- Performs read-modify-write of the 26-bit partial-sum SRAM (OT) for every pixel.
- On the last group, adds bias, applies ReLU, requantises, saturates and writes 16-bit results to output SRAM O0/O1.
- Sits between the conv MAC array (psum producer) and the OT, BIAS and O SRAMs. All SRAMs are single-port with 1-cycle synchronous read.

---
 rtl/psum_accum_ctrl_if.sv | 13 +
 rtl/psum_accum_ctrl.sv | 138 +++++++++++++
 tb/tb_psum_accum_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_accum_ctrl_if.sv
// Partial-sum stream from the conv MAC array into the accumulation controller.
// master: psum producer (drives in_valid/in_psum, samples in_ready)
// slave : psum_accum_ctrl (samples in_valid/in_psum, drives in_ready)
interface psum_accum_ctrl_if #(
  parameter int PSUM_W = 26
);
  logic              in_valid;
  logic              in_ready;
  logic [PSUM_W-1:0] in_psum;

  modport master (output in_valid, output in_psum, input in_ready);
  modport slave  (input in_valid, input in_psum, output in_ready);
endinterface

// File: rtl/psum_accum_ctrl.sv
// Partial-sum accumulation controller for one output channel.
// Each pass walks NUM_PIX pixels in raster order and does a read-modify-write of
// the OT partial-sum SRAM. On the last channel group it instead adds the bias,
// applies ReLU, requantises and saturates, and writes O0/O1.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   start, cfg_*                   pass kick-off and its configuration
//   in_if (slave)                  psum stream: in_valid / in_ready / in_psum
//   ot_we/ot_addr/ot_din/ot_dout   OT SRAM (1-cycle synchronous read)
//   bias_addr/bias_dout            bias SRAM (1-cycle synchronous read)
//   o_we0/o_we1/o_addr/o_din       output SRAMs O0 / O1
//   busy, done                     pass in progress / final write retired
module psum_accum_ctrl #(
  parameter int NUM_PIX = 3136,
  parameter int PSUM_W  = 26,
  parameter int OUT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cfg_first,
  input  logic              cfg_last,
  input  logic [5:0]        cfg_och,
  input  logic [3:0]        cfg_shift,
  psum_accum_ctrl_if.slave  in_if,
  output logic              ot_we,
  output logic [11:0]       ot_addr,
  output logic [PSUM_W-1:0] ot_din,
  input  logic [PSUM_W-1:0] ot_dout,
  output logic [5:0]        bias_addr,
  input  logic [15:0]       bias_dout,
  output logic              o_we0,
  output logic              o_we1,
  output logic [12:0]       o_addr,
  output logic [OUT_W-1:0]  o_din,
  output logic              busy,
  output logic              done
);
  localparam int CW   = 12;
  localparam int MAXV = (1 << (OUT_W - 1)) - 1;

  typedef enum logic [2:0] {IDLE, BIAS_RD, BIAS_CAP, RUN, DRAIN, DONE} state_t;
  state_t state, nxt;

  logic              first_r, last_r;
  logic [5:0]        och_r;
  logic [3:0]        shift_r;
  logic [15:0]       bias_r;
  logic [CW-1:0]     pix, p_r;
  logic [PSUM_W-1:0] psum_r;
  logic              s1_vld;
  logic              acc, last_pix, wr_ot, wr_o;
  logic [PSUM_W-1:0] sum;
  logic [PSUM_W:0]   v, relu, q;
  logic [OUT_W-1:0]  o_val;

  assign last_pix = (pix == CW'(NUM_PIX - 1));
  // Middle passes share the OT port between the S0 read and the S1 write,
  // so a new psum is taken only when S1 is empty.
  assign in_if.in_ready = (state == RUN) && (first_r || last_r || !s1_vld);
  assign acc = in_if.in_valid && in_if.in_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt       = state;
    busy      = 1'b0;
    done      = 1'b0;
    bias_addr = '0;
    case (state)
      IDLE:     if (start) nxt = BIAS_RD;
      BIAS_RD:  begin busy = 1'b1; bias_addr = och_r; nxt = BIAS_CAP; end
      BIAS_CAP: begin busy = 1'b1; nxt = RUN; end
      RUN:      begin busy = 1'b1; if (acc && last_pix) nxt = DRAIN; end
      // S1 always holds the final pixel here; its write issues this cycle.
      DRAIN:    begin busy = 1'b1; nxt = DONE; end
      DONE:     begin done = 1'b1; nxt = IDLE; end
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_r <= 1'b0;
      last_r  <= 1'b0;
      och_r   <= '0;
      shift_r <= '0;
      bias_r  <= '0;
      pix     <= '0;
      p_r     <= '0;
      psum_r  <= '0;
      s1_vld  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        first_r <= cfg_first;
        last_r  <= cfg_last;
        och_r   <= cfg_och;
        shift_r <= cfg_shift;
      end
      if (state == BIAS_CAP) bias_r <= bias_dout;
      s1_vld <= acc;
      if (acc) begin
        psum_r <= in_if.in_psum;
        p_r    <= pix;
        pix    <= last_pix ? '0 : pix + CW'(1);
      end else if (state == DONE) begin
        pix <= '0;
      end
    end
  end

  // S1 arithmetic: psum accumulation wraps at PSUM_W; the bias add is one bit
  // wider so it cannot wrap before ReLU/saturation.
  always_comb begin
    sum   = (first_r ? '0 : ot_dout) + psum_r;
    v     = {sum[PSUM_W-1], sum} + {{(PSUM_W + 1 - 16){bias_r[15]}}, bias_r};
    relu  = v[PSUM_W] ? '0 : v;
    q     = relu >> shift_r;
    o_val = (q > (PSUM_W + 1)'(MAXV)) ? OUT_W'(MAXV) : q[OUT_W-1:0];
  end

  assign wr_ot = s1_vld && !last_r;
  assign wr_o  = s1_vld && last_r;

  always_comb begin
    ot_we   = wr_ot;
    ot_din  = wr_ot ? sum : '0;
    ot_addr = '0;
    if (wr_ot)               ot_addr = p_r;
    else if (acc && !first_r) ot_addr = pix;
    o_we0  = wr_o && !och_r[0];
    o_we1  = wr_o && och_r[0];
    o_addr = wr_o ? 13'(p_r) : '0;
    o_din  = wr_o ? o_val : '0;
  end
endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Bench for psum_accum_ctrl with NUM_PIX=16: SRAM models for OT/BIAS/O0/O1,
// per-cycle handshake/write checks, and a pixel-level reference of each pass.
module tb_psum_accum_ctrl;
  localparam int NP = 16, PW = 26, OW = 16;

  logic clk = 0, rst_n = 0, start = 0, cfg_first = 0, cfg_last = 0;
  logic [5:0] cfg_och = 0;
  logic [3:0] cfg_shift = 0;
  logic ot_we, o_we0, o_we1, busy, done;
  logic [11:0] ot_addr;
  logic [PW-1:0] ot_din, ot_dout;
  logic [5:0] bias_addr;
  logic [15:0] bias_dout;
  logic [12:0] o_addr;
  logic [OW-1:0] o_din;

  psum_accum_ctrl_if #(.PSUM_W(PW)) pif ();

  psum_accum_ctrl #(.NUM_PIX(NP), .PSUM_W(PW), .OUT_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_first(cfg_first), .cfg_last(cfg_last),
    .cfg_och(cfg_och), .cfg_shift(cfg_shift), .in_if(pif),
    .ot_we(ot_we), .ot_addr(ot_addr), .ot_din(ot_din), .ot_dout(ot_dout),
    .bias_addr(bias_addr), .bias_dout(bias_dout),
    .o_we0(o_we0), .o_we1(o_we1), .o_addr(o_addr), .o_din(o_din),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  // SRAM models
  logic [PW-1:0] ot_mem [NP];
  logic [15:0]   bias_mem [64];
  logic [OW-1:0] o0_mem [NP], o1_mem [NP];
  logic ld_en = 0, o_clr = 0;
  logic [3:0] ld_addr = 0;
  logic [PW-1:0] ld_data = 0;

  always @(posedge clk) begin
    if (ld_en) ot_mem[ld_addr] <= ld_data;
    else if (ot_we) ot_mem[ot_addr[3:0]] <= ot_din;
    ot_dout   <= ot_mem[ot_addr[3:0]];
    bias_dout <= bias_mem[bias_addr];
    if (o_clr) begin
      for (int i = 0; i < NP; i++) begin o0_mem[i] <= '0; o1_mem[i] <= '0; end
    end else begin
      if (o_we0) o0_mem[o_addr[3:0]] <= o_din;
      if (o_we1) o1_mem[o_addr[3:0]] <= o_din;
    end
  end

  // Reference model: whole-pass arithmetic per pixel
  int m_ot [NP], m_o0 [NP], m_o1 [NP], psq [NP];
  int checks = 0, errors = 0;

  typedef struct { int ot; int psum; int exp; } vec_t;
  vec_t tbl [NP];

  function automatic int wrap(input int x);
    logic [PW-1:0] t;
    t = x[PW-1:0];
    return int'($signed(t));
  endfunction

  function automatic int requant(input int s, input int b, input int sh);
    int v;
    v = s + b;
    if (v < 0) v = 0;
    v = v >>> sh;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  function automatic void model_pass(input bit f, input bit l, input int och, input int sh);
    int b, s;
    b = int'($signed(bias_mem[och]));
    for (int p = 0; p < NP; p++) begin
      s = wrap((f ? 0 : m_ot[p]) + psq[p]);
      if (!l) m_ot[p] = s;
      else if (och[0]) m_o1[p] = requant(s, b, sh);
      else m_o0[p] = requant(s, b, sh);
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic compare_mems(input string tag);
    for (int p = 0; p < NP; p++) begin
      chk({tag, "_ot"}, 64'(ot_mem[p]), 64'(m_ot[p][PW-1:0]));
      chk({tag, "_o0"}, 64'(o0_mem[p]), 64'(m_o0[p]));
      chk({tag, "_o1"}, 64'(o1_mem[p]), 64'(m_o1[p]));
    end
  endtask

  task automatic check_zero_outs(input string tag);
    chk({tag, "_in_ready"}, 64'(pif.in_ready), 0);
    chk({tag, "_ot_we"}, 64'(ot_we), 0);
    chk({tag, "_ot_addr"}, 64'(ot_addr), 0);
    chk({tag, "_ot_din"}, 64'(ot_din), 0);
    chk({tag, "_bias_addr"}, 64'(bias_addr), 0);
    chk({tag, "_o_we"}, 64'({o_we0, o_we1}), 0);
    chk({tag, "_o_addr"}, 64'(o_addr), 0);
    chk({tag, "_o_din"}, 64'(o_din), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
  endtask

  task automatic load_ot(input int a, input int val);
    @(negedge clk);
    ld_en = 1; ld_addr = a[3:0]; ld_data = val[PW-1:0];
    @(negedge clk);
    ld_en = 0;
  endtask

  task automatic run_pass(input bit f, input bit l, input int och, input int sh,
                          input int gap_at, input int gap_len, input bit bubbles,
                          input int rst_at, input bit steady);
    int idx = 0, cyc = 0, prev_p = 0, done_cnt = 0, done_cyc = -1;
    int first_acc = -1, last_acc = -1, gap = 0, exp_rdy;
    bit prev_acc = 0, rdy, acc, v, fin = 0;
    @(negedge clk);
    start = 1; cfg_first = f; cfg_last = l; cfg_och = och[5:0]; cfg_shift = sh[3:0];
    while (!fin && cyc < 400) begin
      @(negedge clk);
      if (cyc == 0) begin
        chk("bias_addr", 64'(bias_addr), 64'(och));
        chk("busy_start", 64'(busy), 1);
        start = 0;
      end else if (idx < NP) begin
        // stray starts and cfg noise while busy must be ignored
        start = ($urandom_range(0, 7) == 0);
        cfg_first = 1'($urandom); cfg_last = 1'($urandom);
        cfg_och = 6'($urandom); cfg_shift = 4'($urandom);
      end else start = 0;
      chk("we_onehot", 64'($countones({ot_we, o_we0, o_we1}) <= 1), 1);
      chk("ot_we", 64'(ot_we), 64'(prev_acc && !l));
      chk("o_we0", 64'(o_we0), 64'(prev_acc && l && !och[0]));
      chk("o_we1", 64'(o_we1), 64'(prev_acc && l && och[0]));
      if (prev_acc) chk("wr_addr", l ? 64'(o_addr) : 64'(ot_addr), 64'(prev_p));
      if (rst_at >= 0 && idx == rst_at) begin
        rst_n = 0; start = 0;
        #1 check_zero_outs("rst_mid");
        repeat (3) begin
          @(negedge clk);
          chk("rst_no_done", 64'(done), 0);
          chk("rst_no_we", 64'({ot_we, o_we0, o_we1}), 0);
        end
        pif.in_valid = 0;
        rst_n = 1;
        return;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("idle_after_done", 64'(busy), 0);
        start = 0; fin = 1;
      end
      if (done) begin
        done_cnt++; done_cyc = cyc;
        chk("busy_in_done", 64'(busy), 0);
        start = 1; // arrives in DONE: must not launch a pass
      end
      if (idx >= NP) v = 0;
      else if (idx == gap_at && gap < gap_len) begin v = 0; gap++; end
      else if (bubbles) v = ($urandom_range(0, 3) != 0);
      else v = 1;
      pif.in_valid = v;
      pif.in_psum = v ? psq[idx][PW-1:0] : PW'($urandom);
      #1;
      rdy = pif.in_ready;
      acc = v && rdy;
      if (cyc < 2 || idx >= NP) exp_rdy = 0;
      else exp_rdy = (f || l) ? 1 : int'(!prev_acc);
      chk("in_ready", 64'(rdy), 64'(exp_rdy));
      if (acc && !f) begin
        chk("rd_ot_we", 64'(ot_we), 0);
        chk("rd_addr", 64'(ot_addr), 64'(idx));
      end
      if (acc) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc; prev_p = idx; idx++;
      end
      prev_acc = acc;
      cyc++;
    end
    pif.in_valid = 0;
    chk("done_count", 64'(done_cnt), 1);
    chk("done_latency", 64'(done_cyc - last_acc), 2);
    if (steady) begin
      chk("first_accept", 64'(first_acc), 2);
      chk("accept_span", 64'(last_acc - first_acc), 64'((f || l) ? NP - 1 : 2 * (NP - 1)));
    end
    model_pass(f, l, och, sh);
    compare_mems(l ? "last" : (f ? "first" : "mid"));
  endtask

  initial begin
    tbl[0]  = '{-100, 0, 0};        tbl[1]  = '{16777216, 0, 32767};
    tbl[2]  = '{5, 0, 0};           tbl[3]  = '{6, 0, 1};
    tbl[4]  = '{32772, 0, 32767};   tbl[5]  = '{32773, 0, 32767};
    tbl[6]  = '{100, -50, 45};      tbl[7]  = '{0, 4, 0};
    tbl[8]  = '{0, 5, 0};           tbl[9]  = '{1000, 1000, 1995};
    tbl[10] = '{33554431, 1, 0};    tbl[11] = '{-33554432, -1, 32767};
    tbl[12] = '{32000, 767, 32762}; tbl[13] = '{-20000, 20010, 5};
    tbl[14] = '{12, -7, 0};         tbl[15] = '{40, 0, 35};

    for (int i = 0; i < 64; i++) bias_mem[i] = 16'($urandom);
    bias_mem[3] = 16'hFFFB;
    bias_mem[4] = 16'hFFFB;
    for (int i = 0; i < NP; i++) begin m_o0[i] = 0; m_o1[i] = 0; m_ot[i] = 0; end
    pif.in_valid = 0; pif.in_psum = '0;

    o_clr = 1;
    repeat (3) @(negedge clk);
    o_clr = 0;
    check_zero_outs("reset");
    rst_n = 1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 0);

    // first pass: psum = p+1
    for (int p = 0; p < NP; p++) psq[p] = p + 1;
    run_pass(1, 0, 0, 0, -1, 0, 0, -1, 1);
    // middle pass: psum = 10
    for (int p = 0; p < NP; p++) psq[p] = 10;
    run_pass(0, 0, 1, 0, -1, 0, 0, -1, 1);
    for (int p = 0; p < NP; p += 5) chk("mid_ot_p11", 64'(ot_mem[p]), 64'(p + 11));
    // last pass och=3, bias=-5, shift=1
    for (int p = 0; p < NP; p++) psq[p] = 0;
    run_pass(0, 1, 3, 1, -1, 0, 0, -1, 1);
    for (int p = 0; p < NP; p++) chk("last_o1_hand", 64'(o1_mem[p]), 64'((p + 6) >> 1));

    // table: ReLU, saturation and wrap corners, och=4 -> O0, bias=-5, shift=0
    for (int i = 0; i < NP; i++) begin
      load_ot(i, tbl[i].ot);
      m_ot[i] = wrap(tbl[i].ot);
      psq[i] = tbl[i].psum;
    end
    run_pass(0, 1, 4, 0, -1, 0, 0, -1, 1);
    for (int i = 0; i < NP; i++) chk("tbl_o0", 64'(o0_mem[i]), 64'(tbl[i].exp));

    // in_valid gap of 3 cycles at pixel 5 of a middle pass
    for (int p = 0; p < NP; p++) psq[p] = wrap(int'($urandom_range(0, 4000)) - 2000);
    run_pass(0, 0, 5, 0, 5, 3, 0, -1, 0);

    // reset at pixel 7 of a middle pass, then a clean first pass
    run_pass(0, 0, 2, 0, -1, 0, 0, 7, 0);
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 0);
    for (int p = 0; p < NP; p++) psq[p] = wrap(int'($urandom));
    run_pass(1, 0, 6, 0, -1, 0, 0, -1, 1);

    // randomized passes
    for (int n = 0; n < 14; n++) begin
      bit f, l, bb;
      int och, sh;
      f = ($urandom_range(0, 3) == 0);
      l = ($urandom_range(0, 2) == 0);
      och = $urandom_range(0, 63);
      sh = $urandom_range(0, 15);
      bb = 1'($urandom);
      for (int p = 0; p < NP; p++)
        psq[p] = ($urandom_range(0, 3) == 0) ? wrap(int'($urandom))
                                             : int'($urandom_range(0, 80000)) - 40000;
      run_pass(f, l, och, sh, -1, 0, bb, -1, !bb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
